sram_controller: RTL and testbench

Multi-cycle controller sequencing each 32-bit load/store from the MEM stage onto an external 16-bit asynchronous SRAM as two half-word accesses. It produces the `ready` signal the hazard unit uses to stall the pipeline: `Hazard = (MEM_W_EN | MEM_R_EN) & ~ready`. It also holds the read data until the MEM stage advances.

---
 rtl/sram_controller_pkg.sv | 14 +
 rtl/sram_controller.sv | 91 +++++++++
 tb/tb_sram_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and widths for the two-phase 32-bit to 16-bit SRAM controller.
package sram_controller_pkg;
  localparam int SRAM_DQ_W   = 16;
  localparam int SRAM_ADDR_W = 18;
  localparam int WORD_W      = 32;
  localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;
endpackage

// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage load/store as two half-word accesses on an async SRAM.
// ready is low from request acceptance until the DONE cycle; rdata holds until the next load.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t                 state, state_nx;
  logic [3:0]             cnt;
  logic [WORD_IDX_W-1:0]  addr_q;
  logic [WORD_W-1:0]      wdata_q;
  logic                   op_wr;
  logic                   last, active, hi;
  logic [SRAM_DQ_W-1:0]   dq_out;
  logic                   unused;

  assign unused = ^{address[WORD_W-1:19], address[1:0]};
  assign last   = (cnt == LAST_CNT);
  assign active = (state == LOW) || (state == HIGH);
  assign hi     = (state == HIGH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            addr_q  <= address[18:2];
            wdata_q <= wdata;
            op_wr   <= wr_en;
            cnt     <= '0;
          end
        end
        LOW, HIGH: begin
          cnt <= last ? 4'd0 : cnt + 4'd1;
          if (!op_wr && last) begin
            if (hi) rdata[31:16] <= sram_dq;
            else    rdata[15:0]  <= sram_dq;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rd_en || wr_en) state_nx = LOW;
      LOW:     if (last) state_nx = HIGH;
      HIGH:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With a one-cycle phase there is no room to release the strobe early, so it stays low.
  always_comb begin
    ready     = (state == DONE) || ((state == IDLE) && !(rd_en || wr_en));
    sram_addr = active ? {addr_q, hi} : '0;
    sram_we_n = !(active && op_wr && (!last || (WAIT_CYCLES == 0)));
    sram_oe_n = !(active && !op_wr);
    dq_out    = hi ? wdata_q[31:16] : wdata_q[15:0];
  end

  assign sram_dq = (active && op_wr) ? dq_out : {SRAM_DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 1 and 0), each with a half-word SRAM model.
module tb_sram_controller;

  logic clk;
  logic rst_n;
  logic mem_clr;

  logic        rd_en_1, wr_en_1, ready_1, we_n_1, oe_n_1;
  logic [31:0] address_1, wdata_1, rdata_1;
  logic [17:0] sram_addr_1;
  wire  [15:0] dq_1;

  logic        rd_en_0, wr_en_0, ready_0, we_n_0, oe_n_0;
  logic [31:0] address_0, wdata_0, rdata_0;
  logic [17:0] sram_addr_0;
  wire  [15:0] dq_0;

  logic [15:0] mem_1 [0:1023];
  logic [15:0] mem_0 [0:1023];
  logic [31:0] ref_1 [0:511];
  logic [31:0] ref_0 [0:511];
  logic [31:0] exp_rd_1, exp_rd_0;

  int n_chk;
  int n_fail;

  sram_controller #(.WAIT_CYCLES(1)) u_wc1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_1), .wr_en(wr_en_1),
    .address(address_1), .wdata(wdata_1), .rdata(rdata_1), .ready(ready_1),
    .sram_dq(dq_1), .sram_addr(sram_addr_1), .sram_we_n(we_n_1), .sram_oe_n(oe_n_1)
  );

  sram_controller #(.WAIT_CYCLES(0)) u_wc0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en_0), .wr_en(wr_en_0),
    .address(address_0), .wdata(wdata_0), .rdata(rdata_0), .ready(ready_0),
    .sram_dq(dq_0), .sram_addr(sram_addr_0), .sram_we_n(we_n_0), .sram_oe_n(oe_n_0)
  );

  // Async SRAM models: drive the bus while output-enabled, latch writes while the strobe is low.
  assign dq_1 = (!oe_n_1 && we_n_1) ? mem_1[sram_addr_1[9:0]] : 16'hzzzz;
  assign dq_0 = (!oe_n_0 && we_n_0) ? mem_0[sram_addr_0[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem_1[i] <= 16'h0;
        mem_0[i] <= 16'h0;
      end
    end else begin
      if (!we_n_1) mem_1[sram_addr_1[9:0]] <= dq_1;
      if (!we_n_0) mem_0[sram_addr_0[9:0]] <= dq_0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        we_n;
    logic        oe_n;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rdata;
  } obs_t;

  typedef struct {
    int          w;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  function automatic obs_t observe(input int w);
    obs_t o;
    if (w == 1) o = '{ready_1, we_n_1, oe_n_1, sram_addr_1, dq_1, rdata_1};
    else        o = '{ready_0, we_n_0, oe_n_0, sram_addr_0, dq_0, rdata_0};
    return o;
  endfunction

  task automatic drive(input int w, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 1) begin
      rd_en_1 = rd; wr_en_1 = wr; address_1 = a; wdata_1 = d;
    end else begin
      rd_en_0 = rd; wr_en_0 = wr; address_0 = a; wdata_0 = d;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One access from the IDLE cycle (cycle 0) through DONE; inputs are scrambled mid-access.
  task automatic access(input int w, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
    int          lat;
    int          half;
    int          pc;
    obs_t        o;
    logic [8:0]  idx;
    logic [31:0] exp_rd;
    lat = 2 * (w + 1) + 1;
    idx = a[10:2];
    @(posedge clk); #1 drive(w, rd, wr, a, d);
    @(negedge clk); o = observe(w);
    chk("req_ready", {31'b0, o.ready}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1 drive(w, 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(negedge clk); o = observe(w);
      if (c < lat) begin
        half = (c - 1) / (w + 1);
        pc   = (c - 1) % (w + 1);
        chk("busy_ready", {31'b0, o.ready}, 32'd0);
        chk("sram_addr", {14'b0, o.addr}, {14'b0, a[18:2], half[0]});
        if (wr) begin
          chk("wr_dq", {16'b0, o.dq}, {16'b0, (half == 1) ? d[31:16] : d[15:0]});
          chk("wr_we_n", {31'b0, o.we_n}, {31'b0, (pc == w) && (w != 0)});
          chk("wr_oe_n", {31'b0, o.oe_n}, 32'd1);
        end else begin
          chk("rd_oe_n", {31'b0, o.oe_n}, 32'd0);
          chk("rd_we_n", {31'b0, o.we_n}, 32'd1);
        end
      end else begin
        chk("done_ready", {31'b0, o.ready}, 32'd1);
        chk("done_strobes", {30'b0, o.we_n, o.oe_n}, 32'd3);
        chk("done_dq_z", {16'b0, o.dq}, 32'h0000zzzz);
      end
    end
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
    if (w == 1) begin
      if (wr) ref_1[idx] = d;
      else    exp_rd_1 = ref_1[idx];
      exp_rd = exp_rd_1;
    end else begin
      if (wr) ref_0[idx] = d;
      else    exp_rd_0 = ref_0[idx];
      exp_rd = exp_rd_0;
    end
    chk("rdata", o.rdata, exp_rd);
    got = o.rdata;
  endtask

  task automatic chk_quiet(input string name, input int w, input logic exp_ready);
    obs_t o;
    o = observe(w);
    chk({name, "_ready"}, {31'b0, o.ready}, {31'b0, exp_ready});
    chk({name, "_strobes"}, {30'b0, o.we_n, o.oe_n}, 32'd3);
    chk({name, "_dq_z"}, {16'b0, o.dq}, 32'h0000zzzz);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [31:0] got;
    obs_t        o;
    n_chk  = 0;
    n_fail = 0;

    tbl[0] = '{1, 1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[1] = '{1, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 32'hDEAD_BEEF};
    tbl[2] = '{1, 1'b1, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    tbl[3] = '{1, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 32'hA5A5_A5A5};
    tbl[4] = '{0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000};
    tbl[5] = '{0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_5678};
    tbl[6] = '{1, 1'b0, 1'b1, 32'hFFF8_000B, 32'h1111_2222, 32'hA5A5_A5A5};
    tbl[7] = '{1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1111_2222};

    for (int i = 0; i < 512; i++) begin
      ref_1[i] = 32'h0;
      ref_0[i] = 32'h0;
    end
    exp_rd_1 = 32'h0;
    exp_rd_0 = 32'h0;
    rst_n    = 1'b0;
    mem_clr  = 1'b1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      o = observe(w);
      chk_quiet("reset", w, 1'b1);
      chk("reset_addr", {14'b0, o.addr}, 32'd0);
      chk("reset_rdata", o.rdata, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1; mem_clr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      access(tbl[i].w, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, got);
      chk("tbl_rdata", got, tbl[i].exp);
    end

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_quiet("idle", 1, 1'b1);
    end

    // Store aborted by reset after its low half: the high half must never reach the SRAM.
    @(posedge clk); #1 drive(1, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0; drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("abort", 1, 1'b1);
    chk("abort_rdata", rdata_1, 32'd0);
    chk("abort_rdata_wc0", rdata_0, 32'd0);
    chk("abort_addr", {14'b0, sram_addr_1}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_low_half", {16'b0, mem_1[10'd32]}, 32'h0000_F00D);
    chk("abort_high_half", {16'b0, mem_1[10'd33]}, 32'h0000_0000);
    ref_1[16] = 32'h0000_F00D;
    exp_rd_1  = 32'h0;
    exp_rd_0  = 32'h0;
    access(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, got);

    for (int n = 0; n < 150; n++) begin
      int          w;
      logic        rd, wr;
      logic [31:0] a;
      w  = $urandom_range(0, 1);
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 511)) << 2);
      access(w, rd, wr, a, $urandom, got);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk_quiet("gap", w, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
